// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width and FSM state encoding.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

endpackage

// File: rtl/nibble_add4.sv
// Four-bit ripple-carry adder stage, purely combinational, shared by every nibble of a wide add.
module nibble_add4
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  logic rippleCarry;

  // Bit-by-bit ripple so the stage mirrors a real 4-bit adder cell.
  always_comb begin
    s = '0;
    rippleCarry = ci;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i] = a[i] ^ b[i] ^ rippleCarry;
      rippleCarry = (a[i] & b[i]) | (rippleCarry & (a[i] ^ b[i]));
    end
    co = rippleCarry;
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle wide adder: sequences operands through one 4-bit adder, LS nibble first,
// chaining the carry through a flop and collecting the result nibbles into a shift register.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIBBLES = 4,
  localparam int WIDTH = NIBBLE_W * NIBBLES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  stateT state, stateNext;

  logic [IDX_W-1:0]    idx;
  logic                carry;
  logic [WIDTH-1:0]    aReg, bReg, partial, partialNext;
  logic [NIBBLE_W-1:0] addS;
  logic                addCo;
  logic                accept, lastNibble;

  assign accept     = start && (state != RUN);
  assign lastNibble = (state == RUN) && (idx == LAST_IDX);

  nibble_add4 adder (
    .a  (aReg[NIBBLE_W-1:0]),
    .b  (bReg[NIBBLE_W-1:0]),
    .ci (carry),
    .s  (addS),
    .co (addCo)
  );

  // The fresh nibble enters at the top so after NIBBLES shifts the LS nibble sits at bit 0.
  always_comb begin
    partialNext = partial >> NIBBLE_W;
    partialNext[WIDTH-1 -: NIBBLE_W] = addS;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    stateNext = start ? RUN : IDLE;
      RUN:     stateNext = (idx == LAST_IDX) ? DONE : RUN;
      DONE:    stateNext = start ? RUN : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // On the last nibble the low slices still hold the operand MSBs, which feed overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx      <= '0;
      carry    <= 1'b0;
      aReg     <= '0;
      bReg     <= '0;
      partial  <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      aReg  <= op_a;
      bReg  <= op_b;
      carry <= cin;
      idx   <= '0;
    end else if (state == RUN) begin
      aReg    <= aReg >> NIBBLE_W;
      bReg    <= bReg >> NIBBLE_W;
      partial <= partialNext;
      carry   <= addCo;
      idx     <= idx + IDX_W'(1);
      if (lastNibble) begin
        sum      <= partialNext;
        cout     <= addCo;
        overflow <= (aReg[NIBBLE_W-1] == bReg[NIBBLE_W-1]) &&
                    (addS[NIBBLE_W-1] != aReg[NIBBLE_W-1]);
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder with hand-computed results.
module tb_nibble_serial_adder;

  localparam int NIBBLES = 4;
  localparam int WIDTH   = 4 * NIBBLES;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] opA   = '0;
  logic [WIDTH-1:0] opB   = '0;
  logic             cin   = 1'b0;
  logic             busy, done, cout, overflow;
  logic [WIDTH-1:0] sum;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] prevSum = '0;

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op_a     (opA),
    .op_b     (opB),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one start at a negedge and follows the operation to its done pulse.
  task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic c, input logic [WIDTH-1:0] expSum, input logic expCout,
                               input logic expOv, input bit holdStart);
    int  cycles;
    bit  seenDone;
    opA = a; opB = b; cin = c; start = 1'b1;
    @(negedge clock);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    checkOutput({tag, "_sumHeld"}, 32'(sum), 32'(prevSum));
    if (holdStart) begin
      opA = 16'hAAAA; opB = 16'h5555; cin = 1'b1;
    end else begin
      start = 1'b0;
    end
    cycles = 0;
    seenDone = 1'b0;
    while (!seenDone && cycles < 12) begin
      @(negedge clock);
      cycles++;
      if (done) seenDone = 1'b1;
    end
    start = 1'b0;
    checkOutput({tag, "_latency"}, 32'(cycles), 32'(NIBBLES));
    checkOutput({tag, "_sum"}, 32'(sum), 32'(expSum));
    checkOutput({tag, "_cout"}, 32'(cout), 32'(expCout));
    checkOutput({tag, "_ovf"}, 32'(overflow), 32'(expOv));
    checkOutput({tag, "_busyLow"}, 32'(busy), 32'd0);
    prevSum = expSum;
  endtask

  initial begin
    int doneCount;

    #2;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_sum", 32'(sum), 32'd0);
    checkOutput("rst_cout", 32'(cout), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    applyStimulus("basic", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    checkOutput("basic_doneOnce", 32'(done), 32'd0);
    checkOutput("basic_sumKept", 32'(sum), 32'h2345);

    // Asynchronous clear: reset raised between edges must zero outputs before the next edge.
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_sum", 32'(sum), 32'd0);
    checkOutput("async_busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    prevSum = '0;
    @(negedge clock);

    applyStimulus("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    applyStimulus("cinOnly", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    applyStimulus("ovfPos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    @(negedge clock);
    applyStimulus("ovfNeg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    @(negedge clock);

    applyStimulus("holdStart", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b1);
    applyStimulus("backToBack", 16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0, 1'b0);
    @(negedge clock);

    // Abort in the second RUN cycle; no completion may follow.
    opA = 16'h1234; opB = 16'h1111; cin = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_sum", 32'(sum), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    prevSum = '0;
    doneCount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (done) doneCount++;
    end
    checkOutput("abort_noDone", 32'(doneCount), 32'd0);
    checkOutput("abort_sumZero", 32'(sum), 32'd0);

    applyStimulus("afterAbort", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
